// File: rtl/apb_rr_master_pkg.sv
// apb_rr_master_pkg
//   Shared types for the APB round-robin master.
//   - state_e   : sequencer states
//   - MAX_REQ   : largest supported requester count
//   - GNT_IDX_W : width of the grant index and round-robin pointer. It is
//                 sized for MAX_REQ, so one width covers every legal
//                 NUM_REQ (2..8).
package apb_rr_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DERR
    } state_e;

    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned GNT_IDX_W = $clog2(MAX_REQ);

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
//   Combinational round-robin pick. It returns the first valid requester
//   at or after ptr, wrapping around to index 0.
//   Ports:
//     req_valid : per-requester request
//     ptr       : round-robin start index (register lives in the parent)
//     gnt       : one-hot grant (all zero when nothing is valid)
//     gnt_idx   : binary index of the grant
//     gnt_any   : at least one requester is valid
module apb_rr_arbiter
    import apb_rr_master_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [GNT_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [GNT_IDX_W-1:0] gnt_idx,
    output logic                 gnt_any
);

    logic [GNT_IDX_W-1:0] hi_idx;
    logic [GNT_IDX_W-1:0] lo_idx;
    logic                 hi_any;
    logic                 lo_any;

    // Scan from high to low so that the last hit is the lowest index.
    // hi_* covers only indices at or after ptr. lo_* covers all indices and
    // supplies the wrapped choice.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_idx = GNT_IDX_W'(j);
                lo_any = 1'b1;
                if (GNT_IDX_W'(j) >= ptr) begin
                    hi_idx = GNT_IDX_W'(j);
                    hi_any = 1'b1;
                end
            end
        end
        gnt_any = hi_any | lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
        gnt     = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master
//   APB master sequencer shared by NUM_REQ requesters using round-robin
//   arbitration. It decodes the target slave from the top SEL_BITS of the
//   address and runs IDLE -> SETUP -> ACCESS. The completion (read data and
//   error) goes back to the granted requester as a one-cycle registered pulse.
//   Ports:
//     pclock, preset        : clock, synchronous active-high reset
//     req_valid/write/addr/wdata : packed per-requester request bus
//     req_ready             : one-hot accept pulse (combinational, IDLE only)
//     rsp_valid/rdata/err   : one-hot completion pulse with shared data/error
//     paddr/pwdata/pwrite/psel_x/penable : APB master outputs
//     prdata/pready/pslverr : APB slave returns
//   Optional feature: define APB_RR_MASTER_TIMEOUT_EN to add an ACCESS-phase
//   watchdog. After TIMEOUT_CYCLES cycles without pready it ends the transfer
//   with an error.
//
//   state  | meaning
//   IDLE   | no transfer; arbitrate and accept a request
//   SETUP  | psel_x asserted, penable low (one cycle)
//   ACCESS | penable high; wait for pready (or watchdog expiry)
//   DERR   | address decoded to no slave; report an error next edge
module apb_rr_master
    import apb_rr_master_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NO_OF_SLAVES = 7,
    parameter int SEL_BITS     = 3
`ifdef APB_RR_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                             pclock,
    input  logic                             preset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic                             pwrite,
    output logic [NO_OF_SLAVES-1:0]          psel_x,
    output logic                             penable,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr
);

    state_e                  state_q, state_d;
    logic [GNT_IDX_W-1:0]    ptr_q, ptr_d;
    logic [GNT_IDX_W-1:0]    gidx_q, gidx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [NO_OF_SLAVES-1:0] psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

`ifdef APB_RR_MASTER_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    logic [NUM_REQ-1:0]      gnt;
    logic [GNT_IDX_W-1:0]    gnt_idx;
    logic                    gnt_any;

    // The arrays are padded to MAX_REQ entries so that gnt_idx indexes them
    // at its natural width.
    logic [ADDR_WIDTH-1:0]   addr_arr  [MAX_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [MAX_REQ];
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [SEL_BITS-1:0]     sel_idx;

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
        if (i < NUM_REQ) begin : g_real
            assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign addr_arr[i]  = '0;
            assign wdata_arr[i] = '0;
        end
    end

    assign sel_addr = addr_arr[gnt_idx];
    assign sel_idx  = sel_addr[ADDR_WIDTH-1 -: SEL_BITS];

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready   = '0;
`ifdef APB_RR_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    // A reset edge discards this accept, so do not signal it.
                    req_ready = preset ? '0 : gnt;
                    addr_d    = sel_addr;
                    wdata_d   = wdata_arr[gnt_idx];
                    write_d   = |(req_write & gnt);
                    gidx_d    = gnt_idx;
                    ptr_d     = (gnt_idx == GNT_IDX_W'(NUM_REQ - 1)) ? '0
                                                                     : gnt_idx + GNT_IDX_W'(1);
                    if (int'(sel_idx) < NO_OF_SLAVES) begin
                        psel_d  = NO_OF_SLAVES'(1) << sel_idx;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_DERR;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_RR_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << gidx_q;
                    rsp_rdata_d = write_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    state_d     = ST_IDLE;
                end
`ifdef APB_RR_MASTER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << gidx_q;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            ST_DERR: begin
                rsp_valid_d = NUM_REQ'(1) << gidx_q;
                rsp_err_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclock) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_RR_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_RR_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign pwrite    = write_q;
    assign psel_x    = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 7;

    logic               pclock = 1'b0;
    logic               preset;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_write;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic               pwrite;
    logic [NS-1:0]      psel_x;
    logic               penable;
    logic [DW-1:0]      prdata;
    logic               pready;
    logic               pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_rr_master dut (
        .pclock    (pclock),
        .preset    (preset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel_x    (psel_x),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclock = ~pclock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclock);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        preset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        req_valid = 4'b0001;
        #1;
        chk("rst_req_ready", req_ready, 0);
        tick();
        chk("rst_psel", psel_x, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_err", rsp_err, 0);

        // Single write, idx 1, pready in the first ACCESS cycle
        preset = 1'b0;
        pready = 1'b1;
        set_req(0, 1'b1, 32'h2000_0010, 32'h1234_5678);
        req_valid = 4'b0001;
        #1;
        chk("wr_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("wr_setup_psel", psel_x, 7'b0000010);
        chk("wr_setup_penable", penable, 0);
        chk("wr_paddr", paddr, 32'h2000_0010);
        chk("wr_pwdata", pwdata, 32'h1234_5678);
        chk("wr_pwrite", pwrite, 1);
        tick();
        chk("wr_access_penable", penable, 1);
        chk("wr_access_psel", psel_x, 7'b0000010);
        chk("wr_access_rsp", rsp_valid, 0);
        tick();
        chk("wr_rsp_valid", rsp_valid, 4'b0001);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_done_psel", psel_x, 0);
        chk("wr_done_penable", penable, 0);

        // Read with wait states, pointer now 1 -> requester 2 is granted
        pready = 1'b0;
        prdata = 32'hDEAD_BEEF;
        set_req(2, 1'b0, 32'h4000_0000, 32'h0);
        req_valid = 4'b0100;
        #1;
        chk("rd_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("rd_setup_psel", psel_x, 7'b0000100);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rd_wait_penable", penable, 1);
            chk("rd_wait_psel", psel_x, 7'b0000100);
            chk("rd_wait_paddr", paddr, 32'h4000_0000);
            chk("rd_wait_rsp", rsp_valid, 0);
            tick();
        end
        pready = 1'b1;
        chk("rd_last_penable", penable, 1);
        tick();
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 0);

        // Pointer back to 0, then all requesters continuously valid
        preset = 1'b1;
        tick();
        preset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h2000_0000 + i, 32'hA0 + i);
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % NR;
            #1;
            chk("rr_req_ready", req_ready, 4'b0001 << g);
            if (n > 0) chk("rr_rsp_valid", rsp_valid, 4'b0001 << ((n - 1) % NR));
            tick();
            chk("rr_psel", psel_x, 7'b0000010);
            chk("rr_paddr", paddr, 32'h2000_0000 + g);
            chk("rr_pwdata", pwdata, 32'hA0 + g);
            tick();
            chk("rr_penable", penable, 1);
            tick();
        end
        req_valid = '0;
        #1;
        chk("rr_final_ready", req_ready, 0);
        chk("rr_final_rsp", rsp_valid, 4'b0001);

        // Decode error: idx 7 has no slave; pointer is 1
        set_req(1, 1'b0, 32'hE000_0000, 32'h0);
        req_valid = 4'b0010;
        #1;
        chk("derr_req_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("derr_psel", psel_x, 0);
        chk("derr_rsp_early", rsp_valid, 0);
        tick();
        chk("derr_rsp_valid", rsp_valid, 4'b0010);
        chk("derr_rsp_err", rsp_err, 1);
        chk("derr_rsp_rdata", rsp_rdata, 0);
        chk("derr_psel2", psel_x, 0);

        // Slave error on a write to idx 0; pointer is 2
        pslverr = 1'b1;
        set_req(2, 1'b1, 32'h0000_0100, 32'h77);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("serr_psel", psel_x, 7'b0000001);
        tick();
        tick();
        chk("serr_rsp_valid", rsp_valid, 4'b0100);
        chk("serr_rsp_err", rsp_err, 1);
        pslverr = 1'b0;

        // Reset during ACCESS; pointer is 3
        pready = 1'b0;
        set_req(3, 1'b0, 32'h6000_0000, 32'h0);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        chk("abort_setup_psel", psel_x, 7'b0001000);
        tick();
        chk("abort_penable", penable, 1);
        preset = 1'b1;
        tick();
        chk("abort_psel", psel_x, 0);
        chk("abort_penable0", penable, 0);
        chk("abort_rsp", rsp_valid, 0);
        preset = 1'b0;
        tick();
        chk("abort_rsp2", rsp_valid, 0);
        req_valid = 4'b1111;
        #1;
        chk("abort_ptr_reset", req_ready, 4'b0001);
        req_valid = '0;

        // Slave never answers: watchdog expiry vs. indefinite wait
        set_req(0, 1'b0, 32'h2000_0000, 32'h0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
`ifdef APB_RR_MASTER_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            chk("tmo_wait_penable", penable, 1);
            chk("tmo_wait_rsp", rsp_valid, 0);
            tick();
        end
        chk("tmo_last_penable", penable, 1);
        tick();
        chk("tmo_rsp_valid", rsp_valid, 4'b0001);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        chk("tmo_psel", psel_x, 0);
        chk("tmo_penable", penable, 0);
        pready = 1'b1;
        prdata = 32'h55;
        tick();
        chk("tmo_late_rsp", rsp_valid, 0);
        tick();
        chk("tmo_late_rsp2", rsp_valid, 0);
        chk("tmo_late_psel", psel_x, 0);
`else
        for (int k = 0; k < 20; k++) tick();
        chk("hang_penable", penable, 1);
        chk("hang_psel", psel_x, 7'b0000010);
        chk("hang_rsp", rsp_valid, 0);
        pready = 1'b1;
        prdata = 32'h55;
        tick();
        chk("hang_rsp_valid", rsp_valid, 4'b0001);
        chk("hang_rsp_rdata", rsp_rdata, 32'h55);
        chk("hang_rsp_err", rsp_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
